intfmux6_tx: RTL and testbench
==============================

Name: intfmux6_tx

Overview:
- Transmit-side serializer for the FPGA interconnect link; sits directly upstream of the receive demux stage.
- Accepts DATABIT-wide words through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Emits each word as MUX consecutive LINEBIT slices, MSB slice first, with a one-cycle sync strobe on slice 0.
- Frame cadence is free-running: when no word is available, a frame of IDLEPAT slices is sent so the far end never loses sync.

Parameters:
LINEBIT, 12, width of one line slice
MUX, 6, slices per word (2..8)
BITTS, 3, width of phase counter (must hold MUX-1)
IDLEPAT, 12'h000, slice value sent in every slot of an idle frame
DATABIT, MUX*LINEBIT, width of parallel input word

Ports:
iclk38  input  1  line clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
idat  input  DATABIT  parallel word in
ivld  input  1  idat valid
ordy  output  1  FIFO can accept a word (write occurs when ivld & ordy)
odat  output  LINEBIT  serial slice out, registered
osyn  output  1  high on the cycle odat carries slice 0 (MSB slice), registered
ouflow  output  1  one-cycle pulse, coincident with osyn, when an idle frame starts

Behaviour:
- Clock and reset: one clock, iclk38. rst is synchronous, active-high, sampled on the iclk38 rising edge.
- Reset state:
  - cntph=0; FIFO empty.
  - Shift register cleared; odat=0, osyn=0, ouflow=0.
  - ordy forced 0 while rst is high; ordy=1 on the first cycle after release.
- Phase counter cntph (BITTS bits): increments every cycle and wraps MUX-1 -> 0. Never stalls, never resyncs from input.
- Load edge = the rising edge on which cntph==MUX-1.
- At the load edge, if the FIFO is non-empty:
  - Pop the head word W.
  - odat <= W[DATABIT-1 -: LINEBIT]; osyn <= 1; ouflow <= 0.
  - The remaining MUX-1 slices are held in the shift register.
- At the load edge, if the FIFO is empty:
  - odat <= IDLEPAT; osyn <= 1; ouflow <= 1.
  - The shift register is loaded with IDLEPAT in all slots.
- Non-load edges: odat <= next slice in descending order; osyn <= 0; ouflow <= 0.
- Resulting output sequence: slices MSB..LSB occupy MUX consecutive cycles. osyn period is exactly MUX cycles.
- The first osyn after reset occurs after the edge where cntph reaches MUX-1, i.e. the MUX-th edge after reset release. Before that, odat=0 and osyn=0.
- FIFO:
  - 2 entries; ordy = !full, from registered state.
  - A write on the load edge is not seen by that edge's pop decision (pop uses registered empty).
  - Write and pop on the same edge with 1 entry: count stays 1 and the new word becomes the head.
  - When full, ordy=0, so no write is possible even if a pop happens on the same edge. ordy rises the cycle after the pop.
  - ivld while ordy=0 is ignored; the word is not stored.
- Latency: a word written into an empty FIFO on an edge strictly before a load edge appears on odat (slice 0) at that load edge.
- Reset mid-frame: the partially sent frame is abandoned immediately; outputs and state return to reset values on the next edge.

Optional Feature:
Macro INTFMUX6_TX_UFCNT_EN.
- Defined:
  - Adds output ufcnt[7:0], a saturating count of idle frames since reset (increments with each ouflow pulse, holds at 8'hFF, reset 0).
  - Adds input ufclr; when ufclr=1 the counter clears to 0 on that edge. Clear wins over a simultaneous increment.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan (LINEBIT=12, MUX=6, IDLEPAT=12'h000 unless stated):
- Reset, no writes: first osyn at the 6th edge after release, then every 6 cycles. odat=0x000 throughout; ouflow pulses with each osyn.
- Write 72'h123_456_789_ABC_DEF_012 before the first load edge -> odat = 123,456,789,ABC,DEF,012 on 6 consecutive cycles. osyn high only with 123; ouflow=0 for that frame.
- Hold ivld=1 continuously with incrementing words -> ordy drops after 2 writes. Frames stream back-to-back with no idle frames; ordy re-asserts the cycle after each pop; no word lost or duplicated.
- Write exactly on the load edge into an empty FIFO -> that frame is idle (ouflow=1); the word appears in the next frame.
- Assert rst for 1 cycle in the middle of slice 3 -> odat=0 and osyn=0 next cycle; FIFO empty; ordy=0 during reset; sync cadence restarts from cntph=0.
- Serializer output looped into the receive demux stage with random words and random ivld gaps -> the demux output equals the written word sequence, with idle frames decoding as 0.

Source files
------------

// File: rtl/intfmux6_tx.sv
// Transmit-side word serializer: 2-entry input FIFO feeding MUX line slices per frame, MSB slice first.
// Optional idle-frame counter (ufcnt/ufclr) is built when INTFMUX6_TX_UFCNT_EN is defined.
module intfmux6_tx #(
  parameter int                 LINEBIT = 12,
  parameter int                 MUX     = 6,
  parameter int                 BITTS   = 3,
  parameter logic [LINEBIT-1:0] IDLEPAT = 12'h000,
  parameter int                 DATABIT = MUX*LINEBIT
) (
  input  logic               iclk38,
  input  logic               rst,
  input  logic [DATABIT-1:0] idat,
  input  logic               ivld,
  output logic               ordy,
  output logic [LINEBIT-1:0] odat,
  output logic               osyn,
`ifdef INTFMUX6_TX_UFCNT_EN
  input  logic               ufclr,
  output logic [7:0]         ufcnt,
`endif
  output logic               ouflow
);

  localparam int               SRBIT   = (MUX-1)*LINEBIT;
  localparam logic [BITTS-1:0] PH_LAST = BITTS'(MUX-1);

  logic [BITTS-1:0]   cntph;
  logic [DATABIT-1:0] fifo_mem [2];
  logic [1:0]         fifo_cnt;
  logic [SRBIT-1:0]   sreg;
  logic               load;
  logic               wr;
  logic               pop;

  // Pop decisions use only registered FIFO state, so a write on the load edge waits a frame.
  assign load = (cntph == PH_LAST);
  assign ordy = !rst && (fifo_cnt != 2'd2);
  assign wr   = ivld && ordy;
  assign pop  = load && (fifo_cnt != 2'd0);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge iclk38) begin
    if (rst) begin
      cntph <= '0;
    end else if (load) begin
      cntph <= '0;
    end else begin
      cntph <= cntph + 1'b1;
    end
  end

  always_ff @(posedge iclk38) begin
    if (rst) begin
      fifo_cnt <= 2'd0;
    end else begin
      case ({wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // NOTE: FIFO storage is not reset; fifo_cnt alone qualifies which entries hold data.
  always_ff @(posedge iclk38) begin
    if (wr) begin
      if (pop || (fifo_cnt == 2'd0)) begin
        fifo_mem[0] <= idat;
      end else begin
        fifo_mem[1] <= idat;
      end
    end else if (pop) begin
      fifo_mem[0] <= fifo_mem[1];
    end
  end

  always_ff @(posedge iclk38) begin
    if (rst) begin
      odat   <= '0;
      osyn   <= 1'b0;
      ouflow <= 1'b0;
      sreg   <= '0;
    end else if (load) begin
      osyn <= 1'b1;
      if (fifo_cnt != 2'd0) begin
        odat   <= fifo_mem[0][DATABIT-1 -: LINEBIT];
        sreg   <= fifo_mem[0][SRBIT-1:0];
        ouflow <= 1'b0;
      end else begin
        odat   <= IDLEPAT;
        sreg   <= {(MUX-1){IDLEPAT}};
        ouflow <= 1'b1;
      end
    end else begin
      odat   <= sreg[SRBIT-1 -: LINEBIT];
      sreg   <= sreg << LINEBIT;
      osyn   <= 1'b0;
      ouflow <= 1'b0;
    end
  end

`ifdef INTFMUX6_TX_UFCNT_EN
  // Counts on the same edge that raises ouflow; clear has priority.
  always_ff @(posedge iclk38) begin
    if (rst || ufclr) begin
      ufcnt <= 8'h00;
    end else if (load && (fifo_cnt == 2'd0) && (ufcnt != 8'hFF)) begin
      ufcnt <= ufcnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_intfmux6_tx.sv
// Bench for intfmux6_tx: cycle reference model with word scoreboard and a receive-side frame decoder.
module tb_intfmux6_tx;

  localparam int              LB   = 12;
  localparam int              MX   = 6;
  localparam int              DB   = MX*LB;
  localparam logic [LB-1:0]   IDLE = 12'h000;

  logic          iclk38 = 1'b0;
  logic          rst;
  logic [DB-1:0] idat;
  logic          ivld;
  logic          ordy;
  logic [LB-1:0] odat;
  logic          osyn;
  logic          ouflow;
`ifdef INTFMUX6_TX_UFCNT_EN
  logic          ufclr = 1'b0;
  logic [7:0]    ufcnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  intfmux6_tx dut (
    .iclk38 (iclk38),
    .rst    (rst),
    .idat   (idat),
    .ivld   (ivld),
    .ordy   (ordy),
    .odat   (odat),
    .osyn   (osyn),
`ifdef INTFMUX6_TX_UFCNT_EN
    .ufclr  (ufclr),
    .ufcnt  (ufcnt),
`endif
    .ouflow (ouflow)
  );

  always #5 iclk38 = ~iclk38;

  task automatic check(input string tag, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model state, advanced once per cycle on the falling edge.
  bit            m_valid = 1'b0;
  int            m_ph;
  logic [DB-1:0] m_fifo[$];
  logic [LB-1:0] m_slices[$];
  logic [LB-1:0] e_odat;
  logic          e_osyn;
  logic          e_ouflow;
  logic [DB-1:0] sb_q[$];
  logic [DB-1:0] rx_word;
  int            rx_n = 0;
  logic          rx_idle;

  always @(negedge iclk38) begin
    if (m_valid) begin
      check("ordy",   DB'(ordy),   DB'(!rst && (m_fifo.size() < 2)));
      check("osyn",   DB'(osyn),   DB'(e_osyn));
      check("ouflow", DB'(ouflow), DB'(e_ouflow));
      check("odat",   DB'(odat),   DB'(e_odat));
      if (osyn) begin
        rx_word = DB'(odat);
        rx_n    = 1;
        rx_idle = ouflow;
      end else if (rx_n > 0) begin
        rx_word = {rx_word[DB-LB-1:0], odat};
        rx_n++;
      end
      if (rx_n == MX) begin
        if (rx_idle) begin
          check("rx_idle_word", rx_word, {MX{IDLE}});
        end else if (sb_q.size() > 0) begin
          check("rx_word", rx_word, sb_q.pop_front());
        end else begin
          check("rx_unexpected_word", DB'(rx_idle), DB'(1'b1));
        end
        rx_n = 0;
      end
    end

    if (rst) begin
      m_valid  = 1'b1;
      m_ph     = 0;
      m_fifo.delete();
      m_slices.delete();
      sb_q.delete();
      rx_n     = 0;
      e_odat   = '0;
      e_osyn   = 1'b0;
      e_ouflow = 1'b0;
    end else if (m_valid) begin
      bit            accept;
      logic [DB-1:0] w;
      accept = ivld && (m_fifo.size() < 2);
      if (m_ph == MX-1) begin
        e_osyn = 1'b1;
        m_slices.delete();
        if (m_fifo.size() > 0) begin
          w        = m_fifo.pop_front();
          e_ouflow = 1'b0;
          for (int i = MX-1; i >= 0; i--) m_slices.push_back(w[i*LB +: LB]);
        end else begin
          e_ouflow = 1'b1;
          for (int i = 0; i < MX; i++) m_slices.push_back(IDLE);
        end
        e_odat = m_slices.pop_front();
        m_ph   = 0;
      end else begin
        e_osyn   = 1'b0;
        e_ouflow = 1'b0;
        e_odat   = (m_slices.size() > 0) ? m_slices.pop_front() : '0;
        m_ph++;
      end
      if (accept) begin
        m_fifo.push_back(idat);
        sb_q.push_back(idat);
      end
    end
  end

  task automatic step();
    @(posedge iclk38);
    #1;
  endtask

  task automatic wait_osyn();
    for (int i = 0; i < 3*MX && !osyn; i++) @(negedge iclk38);
    check("wait_osyn", DB'(osyn), DB'(1'b1));
  endtask

  initial begin
    logic [DB-1:0] cnt_word;
    bit            acc;

    rst  = 1'b1;
    ivld = 1'b0;
    idat = '0;
    repeat (3) step();

    // Idle cadence after reset.
    rst = 1'b0;
    repeat (4*MX + 2) step();

    // Single word written before the first load edge.
    rst = 1'b1;
    step();
    rst  = 1'b0;
    idat = 72'h123_456_789_ABC_DEF_012;
    ivld = 1'b1;
    step();
    ivld = 1'b0;
    repeat (3*MX) step();

    // Continuous streaming of incrementing words.
    cnt_word = 72'h1;
    ivld     = 1'b1;
    idat     = cnt_word;
    for (int i = 0; i < 10*MX; i++) begin
      @(negedge iclk38);
      acc = ordy;
      step();
      if (acc) begin
        cnt_word = cnt_word + 72'h1;
        idat     = cnt_word;
      end
    end
    ivld = 1'b0;
    repeat (4*MX) step();

    // Write landing exactly on a load edge with an empty FIFO.
    wait_osyn();
    step();
    repeat (4) step();
    idat = 72'hFED_CBA_987_654_321_0AA;
    ivld = 1'b1;
    step();
    ivld = 1'b0;
    repeat (3*MX) step();

    // One-cycle reset in the middle of slice 3, with a second word still queued.
    idat = 72'hAAA_BBB_CCC_DDD_EEE_FFF;
    ivld = 1'b1;
    step();
    idat = 72'h111_222_333_444_555_666;
    step();
    ivld = 1'b0;
    wait_osyn();
    step();
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3*MX) step();

    // Random words with random valid gaps.
    for (int i = 0; i < 400; i++) begin
      idat = {8'($urandom), $urandom, $urandom};
      ivld = ($urandom_range(0, 3) != 0);
      step();
    end
    ivld = 1'b0;
    repeat (4*MX) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
